// File: rtl/spi_master_scheduler.sv
// Round-robin scheduler sharing one SPI master engine among N_REQ chip-select owners.
// Optional watchdog enabled with `define SPI_SCHED_TIMEOUT_EN (adds timeout_err).
module spi_master_scheduler #(
    parameter int N_REQ       = 3,
    parameter int Data_width  = 8,
    parameter int SETUP_CYC   = 2,
    parameter int HOLD_CYC    = 1,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*Data_width-1:0] req_data,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [Data_width-1:0]       rsp_data,
    output logic                        m_start,
    output logic [Data_width-1:0]       m_tx_data,
    input  logic                        m_busy,
    input  logic                        m_done,
    input  logic [Data_width-1:0]       m_rx_data,
    output logic [N_REQ-1:0]            cs_n,
    output logic                        sched_busy
`ifdef SPI_SCHED_TIMEOUT_EN
   ,output logic                        timeout_err
`endif
);
    localparam int MAXC = (SETUP_CYC > HOLD_CYC) ?
                          ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                          ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC);
    localparam int CW = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ARB, SETUP, LAUNCH, WAIT, HOLD, GAP} state_t;

    state_t          state;
    logic [PW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   win;
    logic            found;

    // Search upward from last+1 with wrap, so the previous winner has lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[(int'(last) + k) % N_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(last) + k) % N_REQ);
            end
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= PW'(N_REQ - 1);
            cnt        <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            m_start    <= 1'b0;
            m_tx_data  <= '0;
            cs_n       <= '1;
            sched_busy <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            wd          <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            m_start   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= ARB;
                        sched_busy <= 1'b1;
                    end
                end
                ARB: begin
                    if (found) begin
                        gnt       <= N_REQ'(1) << win;
                        m_tx_data <= req_data[int'(win)*Data_width +: Data_width];
                        last      <= win;
                        cs_n      <= ~(N_REQ'(1) << win);
                        cnt       <= '0;
                        state     <= (SETUP_CYC == 0) ? LAUNCH : SETUP;
                    end else begin
                        state      <= IDLE;
                        sched_busy <= 1'b0;
                    end
                end
                SETUP: begin
                    if (int'(cnt) + 1 >= SETUP_CYC) begin
                        cnt   <= '0;
                        state <= LAUNCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    if (!m_busy) begin
                        m_start <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_done) begin
                        rsp_data  <= m_rx_data;
                        rsp_valid <= N_REQ'(1) << last;
                        cnt       <= '0;
                        state     <= (HOLD_CYC == 0) ? GAP : HOLD;
                    end
                end
                HOLD: begin
                    if (int'(cnt) + 1 >= HOLD_CYC) begin
                        cs_n  <= '1;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    // With HOLD_CYC == 0 this is where cs_n first rises.
                    cs_n <= '1;
                    if (int'(cnt) + 1 >= GAP_CYC) begin
                        cnt        <= '0;
                        state      <= IDLE;
                        sched_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SPI_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
            // Overrides the case above: a stuck engine ends the frame with an all-ones word.
            if (state == LAUNCH || state == WAIT) begin
                if (int'(wd) >= TIMEOUT_CYC && !(state == WAIT && m_done)) begin
                    timeout_err <= 1'b1;
                    rsp_valid   <= N_REQ'(1) << last;
                    rsp_data    <= '1;
                    m_start     <= 1'b0;
                    cnt         <= '0;
                    wd          <= '0;
                    state       <= (HOLD_CYC == 0) ? GAP : HOLD;
                end else begin
                    wd <= wd + 1'b1;
                end
            end else begin
                wd <= '0;
            end
`endif
        end
    end
endmodule

// File: doc/spi_master_scheduler.md
Name: spi_master_scheduler

Overview:
- Round-robin scheduler that shares one SPI master engine among N_REQ requesters.
- Each requester owns one chip-select line.
- The block arbitrates pending requests, asserts the winner's cs_n and applies CS setup time.
- It launches one Data_width-bit transfer on the master engine, returns the received word, then applies CS hold time and an inter-frame gap.
- Sits between client logic and the SPI master datapath; the SPI slave peripherals sit on the far side.

Parameters:
- N_REQ, 3, number of requesters / chip selects (2..8).
- Data_width, 8, SPI word width in bits.
- SETUP_CYC, 2, clk cycles cs_n held low before m_start (0 allowed).
- HOLD_CYC, 1, clk cycles cs_n held low after m_done (0 allowed).
- GAP_CYC, 2, clk cycles all cs_n high before the next arbitration (minimum 1).
- TIMEOUT_CYC, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester pending request, level.
- req_data  in  N_REQ*Data_width  TX word per requester; slice i = [i*Data_width +: Data_width].
- gnt  out  N_REQ  one-hot, 1-cycle pulse when the request is accepted and req_data is captured.
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse when the transfer completes.
- rsp_data  out  Data_width  received word; valid with rsp_valid, held until the next completion.
- m_start  out  1  1-cycle start pulse to the master engine.
- m_tx_data  out  Data_width  word for the engine; stable from m_start until m_done.
- m_busy  in  1  engine busy.
- m_done  in  1  engine 1-cycle completion pulse.
- m_rx_data  in  Data_width  engine received word; valid with m_done.
- cs_n  out  N_REQ  active-low chip selects; at most one low at any time.
- sched_busy  out  1  high in every state except IDLE.

Behaviour:
- Outputs are registered.
- Reset values:
  - gnt = 0, rsp_valid = 0, m_start = 0.
  - rsp_data = 0, m_tx_data = 0.
  - cs_n = all ones, sched_busy = 0.
  - state = IDLE, rr pointer last = N_REQ-1 (so req[0] has first priority), all counters 0.
- States: IDLE, ARB, SETUP, LAUNCH, WAIT, HOLD, GAP.
- IDLE: if |req, go to ARB; otherwise stay in IDLE.
- ARB (one cycle):
  - Winner = first set req bit searching upward from last+1 with wrap-around.
  - Pulse gnt[winner]; capture the req_data slice into m_tx_data; set last = winner; drive cs_n[winner] low.
  - Go to SETUP, or to LAUNCH if SETUP_CYC == 0.
  - If req dropped to all-zero by ARB, return to IDLE with no gnt.
- SETUP: count SETUP_CYC cycles, then go to LAUNCH.
- LAUNCH:
  - If m_busy is low: pulse m_start and go to WAIT.
  - If m_busy is high: wait here; m_start stays low and cs_n stays low.
- WAIT:
  - On m_done: latch m_rx_data into rsp_data and pulse rsp_valid[last] in the same registered update.
  - Then go to HOLD, or to GAP if HOLD_CYC == 0.
  - m_done outside WAIT is ignored.
- HOLD: count HOLD_CYC cycles with cs_n still low, then raise all cs_n and go to GAP.
- GAP: count GAP_CYC cycles with all cs_n high, then go to IDLE.
- Latency for a lone request rising in IDLE (cycle 0 = first edge where req is sampled high):
  - gnt at cycle 1, cs_n low from cycle 1.
  - m_start at cycle 2+SETUP_CYC, assuming m_busy is low.
- Requesters:
  - Must keep req high until gnt is seen.
  - May drop or re-raise req after gnt; a re-raised req is served in a later round.
- Fairness: a continuously requesting client waits at most N_REQ-1 transfers.
- Simultaneous events:
  - A new req during WAIT/HOLD/GAP waits for IDLE.
  - rsp_valid for transfer k and gnt for transfer k+1 never share a cycle (GAP ≥ 1).
- Counters are sized $clog2(max(SETUP_CYC,HOLD_CYC,GAP_CYC)+1) bits, reset to 0 on every state entry, and never wrap.
- Reset mid-transfer: at the next edge all cs_n go high, pending gnt/rsp_valid/m_start are cleared, and the in-flight transfer is dropped with no rsp_valid.

Optional Feature:
- Macro: SPI_SCHED_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, reset 0) and a watchdog counter that runs in LAUNCH+WAIT.
  - If TIMEOUT_CYC cycles elapse without m_done: pulse timeout_err for 1 cycle, pulse rsp_valid[last] with rsp_data = all ones, and go to HOLD.
- Undefined: no port, no counter; WAIT waits indefinitely for m_done.

Test Plan:
- Single request: req=3'b001, req_data[7:0]=8'hA5, engine returns 8'h3C after 16 cycles → gnt[0] at cycle 1, cs_n=3'b110 from cycle 1, m_start at cycle 4, m_tx_data=8'hA5, rsp_valid=3'b001 with rsp_data=8'h3C, cs_n=3'b111 1 cycle after rsp_valid.
- Round-robin: req=3'b111 held high, data 8'h11/8'h22/8'h33 → grant order 0,1,2,0; each m_tx_data matches its slice; never two cs_n bits low.
- Busy back-pressure: m_busy high for 10 cycles at LAUNCH → m_start delayed until first cycle with m_busy low; cs_n[winner] stays low throughout.
- Zero timing: SETUP_CYC=0, HOLD_CYC=0, GAP_CYC=1 → m_start 1 cycle after gnt; cs_n high 1 cycle after rsp_valid; next gnt ≥ 2 cycles after rsp_valid.
- Reset mid-WAIT: assert rst for 1 cycle while cs_n=3'b101 → cs_n=3'b111, sched_busy=0 next edge; no rsp_valid; the next req=3'b100 is granted at gnt[0]? no, at gnt[2] (pointer reset, req[2] only pending).
- With SPI_SCHED_TIMEOUT_EN and TIMEOUT_CYC=32, m_done never pulses → timeout_err pulse 32 cycles after m_start; rsp_valid[last] with rsp_data=8'hFF; then HOLD/GAP and back to IDLE.
